// File: rtl/sh7604_bus_target_pkg.sv
// Shared types for the SH7604 external-bus target.
package sh7604_bus_target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2,
    ST_VEC    = 2'd3
  } BusTgtState_t;

endpackage

// File: rtl/sh7604_bus_target.sv
// SH7604 normal-space bus responder: decodes one CS area, stretches the CPU with
// WAIT_N and turns each bus cycle into one MEM_REQ/MEM_RDY transaction.
module sh7604_bus_target
  import sh7604_bus_target_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter bit BUS16  = 1'b0
) (
  input  logic                                       CLK,
  input  logic                                       RST_N,
  input  logic                                       CE_R,
  input  logic                                       CE_F,
  input  logic [26:0]                                A,
  input  logic [31:0]                                DO,
  output logic [31:0]                                DI,
  input  logic                                       BS_N,
  input  logic                                       CS_N,
  input  logic                                       RD_WR_N,
  input  logic                                       RD_N,
  input  logic [3:0]                                 WE_N,
  output logic                                       WAIT_N,
  input  logic                                       IVECF_N,
  input  logic [7:0]                                 VEC,
  output logic [(BUS16 ? ADDR_W-1 : ADDR_W-2)-1:0]   MEM_A,
  output logic [31:0]                                MEM_DO,
  output logic [3:0]                                 MEM_BE,
  output logic                                       MEM_WE,
  output logic                                       MEM_REQ,
  input  logic [31:0]                                MEM_DI,
  input  logic                                       MEM_RDY
);

  localparam int MA_W = BUS16 ? ADDR_W-1 : ADDR_W-2;

  BusTgtState_t      state, state_nx;
  logic [31:0]       di_nx, do_nx;
  logic [MA_W-1:0]   a_nx;
  logic [3:0]        be_nx;
  logic              we_nx, req_nx, wait_nx;

  // Lane formatting for the selected port width
  logic [ADDR_W-1:0] a_low;
  logic [MA_W-1:0]   a_dec;
  logic [3:0]        be_wr, be_rd;
  logic [31:0]       do_fmt, di_fmt;
  logic              acc_hit, start;
  logic              unused_pins;

  assign a_low   = A[ADDR_W-1:0];
  assign a_dec   = MA_W'(a_low >> (BUS16 ? 1 : 2));
  assign be_wr   = BUS16 ? {2'b00, ~WE_N[1:0]} : ~WE_N;
  assign be_rd   = BUS16 ? 4'h3 : 4'hF;
  assign do_fmt  = BUS16 ? {16'h0, DO[15:0]} : DO;
  assign di_fmt  = BUS16 ? {16'h0, MEM_DI[15:0]} : MEM_DI;
  assign acc_hit = CE_F && !BS_N && !CS_N;
  assign start   = acc_hit && (state == ST_IDLE || state == ST_HOLD);

  // Strobes kept on the port for pin compatibility but not needed for decode
  assign unused_pins = ^{CE_R, RD_N, A[26:ADDR_W]};

  always_comb begin
    state_nx = state;
    di_nx    = DI;
    do_nx    = MEM_DO;
    a_nx     = MEM_A;
    be_nx    = MEM_BE;
    we_nx    = MEM_WE;
    req_nx   = MEM_REQ;
    wait_nx  = WAIT_N;

    case (state)
      ST_IDLE: begin
        if (!start && CE_F && !BS_N && !IVECF_N) begin
          di_nx    = {24'h0, VEC};
          state_nx = ST_VEC;
        end
      end
      ST_ACCESS: begin
        if (MEM_RDY) begin
          if (!MEM_WE) di_nx = di_fmt;
          req_nx   = 1'b0;
          we_nx    = 1'b0;
          wait_nx  = 1'b1;
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!start && CE_F && CS_N) state_nx = ST_IDLE;
      end
      ST_VEC: begin
        if (CE_F && IVECF_N) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase

    // A write with no lane enabled has nothing to do on the memory side
    if (start) begin
      if (RD_WR_N) begin
        a_nx     = a_dec;
        be_nx    = be_rd;
        we_nx    = 1'b0;
        req_nx   = 1'b1;
        wait_nx  = 1'b0;
        state_nx = ST_ACCESS;
      end else if (be_wr == 4'h0) begin
        state_nx = ST_HOLD;
      end else begin
        a_nx     = a_dec;
        be_nx    = be_wr;
        do_nx    = do_fmt;
        we_nx    = 1'b1;
        req_nx   = 1'b1;
        wait_nx  = 1'b0;
        state_nx = ST_ACCESS;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      DI      <= '0;
      MEM_DO  <= '0;
      MEM_A   <= '0;
      MEM_BE  <= '0;
      MEM_WE  <= 1'b0;
      MEM_REQ <= 1'b0;
      WAIT_N  <= 1'b1;
    end else begin
      state   <= state_nx;
      DI      <= di_nx;
      MEM_DO  <= do_nx;
      MEM_A   <= a_nx;
      MEM_BE  <= be_nx;
      MEM_WE  <= we_nx;
      MEM_REQ <= req_nx;
      WAIT_N  <= wait_nx;
    end
  end

endmodule
